seq_serializer: RTL and testbench

Parallel-to-serial front end for the sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a serial `sequence` line that drives the detector's `sequence` input directly. A one-entry pending register lets consecutive words stream with no idle gap between them.

---
 rtl/seq_serializer.sv | 121 ++++++++++++
 tb/tb_seq_serializer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the sequence detector: MSB-first, one bit per clock,
// with a one-entry pending register for gapless streaming. `SER_PARITY_EN appends even parity.
// The serial bit is on port sequence_out, which drives the detector's sequence input.
module seq_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sequence_out,
  output logic             seq_valid,
  output logic             frame_last,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int unsigned FL = WIDTH + 1;
`else
  localparam int unsigned FL = WIDTH;
`endif
  localparam int unsigned CW = $clog2(FL);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [FL-1:0]    sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             din_ready_q, seq_valid_q, frame_last_q, busy_q;
  logic             accept;

  // Shift-register image of a word, parity bit (if any) after the LSB.
  function automatic logic [FL-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SER_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  assign accept = din_valid && din_ready_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = frame_of(din);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          sh_d  = sh_q << 1;
          cnt_d = cnt_q + CW'(1);
          if (accept) begin
            pend_d      = din;
            pend_full_d = 1'b1;
          end
        end else if (pend_full_q) begin
          // din_ready is low while pend is full, so no accept can race this reload.
          sh_d        = frame_of(pend_q);
          pend_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          sh_d  = frame_of(din);
          cnt_d = '0;
        end else begin
          // Final shift leaves sh all-zero so the idle line reads 0.
          sh_d    = sh_q << 1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      din_ready_q  <= 1'b1;
      seq_valid_q  <= 1'b0;
      frame_last_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      din_ready_q  <= !pend_full_d;
      seq_valid_q  <= (state_d == SHIFT);
      frame_last_q <= (state_d == SHIFT) && (cnt_d == LAST);
      busy_q       <= (state_d == SHIFT) || pend_full_d;
    end
  end

  assign din_ready    = din_ready_q;
  assign sequence_out = sh_q[FL-1];
  assign seq_valid    = seq_valid_q;
  assign frame_last   = frame_last_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed self-checking bench for seq_serializer; honours `SER_PARITY_EN like the RTL.
module tb_seq_serializer;

`ifdef SER_PARITY_EN
  localparam int FL = 9;
  localparam logic [8:0] EXP_B0 = 9'h161;
  localparam logic [8:0] EXP_66 = 9'h0CC;
`else
  localparam int FL = 8;
  localparam logic [8:0] EXP_B0 = 9'h0B0;
  localparam logic [8:0] EXP_66 = 9'h066;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, sequence_out, seq_valid, frame_last, busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  seq_serializer #(.WIDTH(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .sequence_out(sequence_out),
    .seq_valid   (seq_valid),
    .frame_last  (frame_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic eb, input logic el, input logic er);
    chk({tag, ".sequence"},   sequence_out, eb);
    chk({tag, ".seq_valid"},  seq_valid,    1'b1);
    chk({tag, ".frame_last"}, frame_last,   el);
    chk({tag, ".din_ready"},  din_ready,    er);
    chk({tag, ".busy"},       busy,         1'b1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".sequence"},   sequence_out, 1'b0);
    chk({tag, ".seq_valid"},  seq_valid,    1'b0);
    chk({tag, ".frame_last"}, frame_last,   1'b0);
    chk({tag, ".din_ready"},  din_ready,    1'b1);
    chk({tag, ".busy"},       busy,         1'b0);
  endtask

  // Expected frame: word MSB-first, then even parity when enabled.
  function automatic logic [8:0] tb_frame(input logic [7:0] w);
`ifdef SER_PARITY_EN
    return {w, ^w};
`else
    return {1'b0, w};
`endif
  endfunction

  task automatic push_bits(input logic [8:0] f);
    for (int b = FL - 1; b >= 0; b--) exp_q.push_back(f[b]);
  endtask

  initial begin
    resetn    = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    repeat (2) step();
    check_idle("in_reset");
    resetn = 1'b1;
    step();
    check_idle("post_reset");

    // Single word 0xB0.
    din = 8'hB0; din_valid = 1'b1;
    step();
    din_valid = 1'b0; din = 8'hFF;
    push_bits(EXP_B0);
    for (int i = 0; i < FL; i++) begin
      check_cycle("single", exp_q.pop_front(), i == FL - 1, 1'b1);
      step();
    end
    check_idle("single_end");

    // Held valid: 0x66 then 0x0F, second word parks in pend.
    din = 8'h66; din_valid = 1'b1;
    step();
    push_bits(EXP_66);
    push_bits(tb_frame(8'h0F));
    for (int i = 0; i < 2 * FL; i++) begin
      check_cycle("stream2", exp_q.pop_front(), (i % FL) == FL - 1, (i == 0) || (i >= FL));
      if (i == 0) din = 8'h0F;
      if (i == 1) begin din_valid = 1'b0; din = 8'h00; end
      step();
    end
    check_idle("stream2_end");

    // Three words back to back; third waits for pend to drain.
    din = 8'hC3; din_valid = 1'b1;
    step();
    push_bits(tb_frame(8'hC3));
    push_bits(tb_frame(8'h5A));
    push_bits(tb_frame(8'hE7));
    for (int i = 0; i < 3 * FL; i++) begin
      check_cycle("stream3", exp_q.pop_front(), (i % FL) == FL - 1, ((i % FL) == 0) || (i >= 2 * FL));
      if (i == 0) din = 8'h5A;
      if (i == 1) din = 8'hE7;
      if (i == FL + 1) begin din_valid = 1'b0; din = 8'h00; end
      step();
    end
    check_idle("stream3_end");

    // Bypass: new word offered only on the last-bit cycle with pend empty.
    din = 8'h3C; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    push_bits(tb_frame(8'h3C));
    push_bits(tb_frame(8'h96));
    for (int i = 0; i < 2 * FL; i++) begin
      check_cycle("bypass", exp_q.pop_front(), (i % FL) == FL - 1, 1'b1);
      if (i == FL - 1) begin din = 8'h96; din_valid = 1'b1; end
      if (i == FL) begin din_valid = 1'b0; din = 8'h00; end
      step();
    end
    check_idle("bypass_end");

    // Mid-frame reset with 0xAA pending.
    din = 8'hFF; din_valid = 1'b1;
    step();
    din = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      check_cycle("pre_rst", 1'b1, 1'b0, i == 0);
      if (i == 1) begin din_valid = 1'b0; din = 8'h00; end
      step();
    end
    resetn = 1'b0;
    #1;
    check_idle("async_rst");
    step();
    resetn = 1'b1;
    step();
    check_idle("rst_release");
    din = 8'h81; din_valid = 1'b1;
    step();
    din_valid = 1'b0; din = 8'h00;
    push_bits(tb_frame(8'h81));
    for (int i = 0; i < FL; i++) begin
      check_cycle("after_rst", exp_q.pop_front(), i == FL - 1, 1'b1);
      step();
    end
    for (int i = 0; i < FL + 2; i++) begin
      check_idle("no_stale");
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
